// File: rtl/pool_rd_bridge.sv
// pool_rd_bridge: read side of the max-pool path.
// Walks the feature map in 2x2 windows, issues word reads, tags each return with its
// window pixel / channel and reports finished output points and image end.
module pool_rd_bridge #(
    parameter int unsigned word_len     = 32,
    parameter int unsigned channel_size = 64,
    parameter int unsigned img_w        = 64,
    parameter int unsigned img_h        = 64,
    parameter int unsigned max_outst    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PcPrb_initAddrEn,
    input  logic [27:0]         PcPrb_initAddr,
    output logic                PrbMem_rdReq,
    output logic [27:0]         PrbMem_rdAddr,
    input  logic                MemPrb_rdGnt,
    input  logic                MemPrb_rdValid,
    input  logic [word_len-1:0] MemPrb_rdData,
    output logic                PrbPu_valid,
    output logic [word_len-1:0] PrbPu_data,
    output logic [1:0]          PrbPu_win,
    output logic [5:0]          PrbPu_ch,
    output logic                pt_en,
    output logic [5:0]          ptr,
    output logic [5:0]          ptc,
    output logic                PrbPc_imgEnd,
    output logic [27:0]         PrbPc_imgEndAddr
);

    localparam int unsigned PtrW      = (max_outst > 1) ? $clog2(max_outst) : 1;
    localparam int unsigned FifoDepth = 1 << PtrW;
    localparam int unsigned OutW      = $clog2(max_outst + 1);

    localparam logic [5:0]      LastCh  = 6'(channel_size - 1);
    localparam logic [5:0]      LastOpc = 6'(img_w / 2 - 1);
    localparam logic [5:0]      LastOpr = 6'(img_h / 2 - 1);
    localparam logic [OutW-1:0] MaxOut  = OutW'(max_outst);
    localparam logic [OutW-1:0] OutOne  = OutW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            r_state;
    logic              r_armed;
    logic [27:0]       r_base;
    logic              r_rd_req;

    // Position of the request currently presented on the memory port
    logic [5:0]        r_ch;
    logic              r_dx;
    logic              r_dy;
    logic [5:0]        r_opc;
    logic [5:0]        r_opr;

    logic [OutW-1:0]   r_outst;
    // Number of oldest in-flight returns that belong to an aborted pass
    logic [OutW-1:0]   r_drop;
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;

    logic [1:0]        r_tag_win  [FifoDepth];
    logic [5:0]        r_tag_ch   [FifoDepth];
    logic [5:0]        r_tag_opr  [FifoDepth];
    logic [5:0]        r_tag_opc  [FifoDepth];
    logic              r_tag_lwin [FifoDepth];
    logic              r_tag_limg [FifoDepth];
    logic [27:0]       r_tag_addr [FifoDepth];

    logic              r_pu_valid;
    logic [word_len-1:0] r_pu_data;
    logic [1:0]        r_pu_win;
    logic [5:0]        r_pu_ch;
    logic              r_pt_en;
    logic [5:0]        r_ptr;
    logic [5:0]        r_ptc;
    logic              r_img_end;
    logic [27:0]       r_img_end_addr;

    logic              w_grant;
    logic              w_pop;
    logic              w_deliver;
    logic              w_ch_last;
    logic              w_last_win;
    logic              w_last_img;
    logic              w_room;
    logic [OutW-1:0]   w_outst_nxt;
    logic [6:0]        w_row;
    logic [6:0]        w_col;
    logic [27:0]       w_pix;
    logic [27:0]       w_addr;

    assign w_grant    = r_rd_req && MemPrb_rdGnt;
    // Returns with nothing outstanding are protocol errors and are ignored
    assign w_pop      = MemPrb_rdValid && (r_outst != '0);
    assign w_deliver  = w_pop && (r_drop == '0) && !PcPrb_initAddrEn;

    assign w_ch_last  = (r_ch == LastCh);
    assign w_last_win = w_ch_last && r_dx && r_dy;
    assign w_last_img = w_last_win && (r_opc == LastOpc) && (r_opr == LastOpr);

    assign w_row  = {r_opr, r_dy};
    assign w_col  = {r_opc, r_dx};
    assign w_pix  = 28'(w_row) * 28'(img_w) + 28'(w_col);
    assign w_addr = r_base + w_pix * 28'(channel_size) + 28'(r_ch);

    // Outstanding count after this cycle's grant and return
    always_comb begin
        w_outst_nxt = r_outst;
        if (w_grant && !w_pop) begin
            w_outst_nxt = r_outst + OutOne;
        end else if (!w_grant && w_pop) begin
            w_outst_nxt = r_outst - OutOne;
        end
    end

    assign w_room = (w_outst_nxt < MaxOut);

    // Tag FIFO write: records what each granted request was for
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_tag_win[r_wr_ptr]  <= {r_dy, r_dx};
            r_tag_ch[r_wr_ptr]   <= r_ch;
            r_tag_opr[r_wr_ptr]  <= r_opr;
            r_tag_opc[r_wr_ptr]  <= r_opc;
            r_tag_lwin[r_wr_ptr] <= w_last_win;
            r_tag_limg[r_wr_ptr] <= w_last_img;
            r_tag_addr[r_wr_ptr] <= w_addr;
        end
    end

    // Control FSM, request walk, outstanding tracking and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_armed        <= 1'b0;
            r_base         <= '0;
            r_rd_req       <= 1'b0;
            r_ch           <= '0;
            r_dx           <= 1'b0;
            r_dy           <= 1'b0;
            r_opc          <= '0;
            r_opr          <= '0;
            r_outst        <= '0;
            r_drop         <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_pu_valid     <= 1'b0;
            r_pu_data      <= '0;
            r_pu_win       <= '0;
            r_pu_ch        <= '0;
            r_pt_en        <= 1'b0;
            r_ptr          <= '0;
            r_ptc          <= '0;
            r_img_end      <= 1'b0;
            r_img_end_addr <= '0;
        end else begin
            r_pu_valid <= 1'b0;
            r_pt_en    <= 1'b0;
            r_img_end  <= 1'b0;

            r_outst <= w_outst_nxt;
            if (w_grant) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end

            // While held in abort everything still in flight is stale
            if (PcPrb_initAddrEn) begin
                r_drop <= w_outst_nxt;
            end else if (w_pop && (r_drop != '0)) begin
                r_drop <= r_drop - OutOne;
            end

            if (w_deliver) begin
                r_pu_valid <= 1'b1;
                r_pu_data  <= MemPrb_rdData;
                r_pu_win   <= r_tag_win[r_rd_ptr];
                r_pu_ch    <= r_tag_ch[r_rd_ptr];
                if (r_tag_lwin[r_rd_ptr]) begin
                    r_pt_en <= 1'b1;
                    r_ptr   <= r_tag_opr[r_rd_ptr];
                    r_ptc   <= r_tag_opc[r_rd_ptr];
                end
                if (r_tag_limg[r_rd_ptr]) begin
                    r_img_end      <= 1'b1;
                    r_img_end_addr <= r_tag_addr[r_rd_ptr];
                end
            end

            if (PcPrb_initAddrEn) begin
                r_base   <= PcPrb_initAddr;
                r_armed  <= 1'b1;
                r_state  <= StIdle;
                r_rd_req <= 1'b0;
                r_ch     <= '0;
                r_dx     <= 1'b0;
                r_dy     <= 1'b0;
                r_opc    <= '0;
                r_opr    <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (r_armed) begin
                            r_state  <= StRun;
                            r_armed  <= 1'b0;
                            r_rd_req <= w_room;
                            r_ch     <= '0;
                            r_dx     <= 1'b0;
                            r_dy     <= 1'b0;
                            r_opc    <= '0;
                            r_opr    <= '0;
                        end
                    end
                    StRun: begin
                        if (w_grant) begin
                            if (w_last_img) begin
                                r_state  <= StDrain;
                                r_rd_req <= 1'b0;
                            end else begin
                                r_rd_req <= w_room;
                            end
                            // Walk order: ch, dx, dy, opc, opr
                            if (!w_ch_last) begin
                                r_ch <= r_ch + 6'd1;
                            end else begin
                                r_ch <= '0;
                                if (!r_dx) begin
                                    r_dx <= 1'b1;
                                end else begin
                                    r_dx <= 1'b0;
                                    if (!r_dy) begin
                                        r_dy <= 1'b1;
                                    end else begin
                                        r_dy <= 1'b0;
                                        if (r_opc != LastOpc) begin
                                            r_opc <= r_opc + 6'd1;
                                        end else begin
                                            r_opc <= '0;
                                            r_opr <= r_opr + 6'd1;
                                        end
                                    end
                                end
                            end
                        end else begin
                            r_rd_req <= w_room;
                        end
                    end
                    StDrain: begin
                        if (w_deliver && r_tag_limg[r_rd_ptr]) begin
                            r_state <= StDone;
                        end
                    end
                    StDone: begin
                        r_state <= StDone;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign PrbMem_rdReq     = r_rd_req;
    assign PrbMem_rdAddr    = w_addr;
    assign PrbPu_valid      = r_pu_valid;
    assign PrbPu_data       = r_pu_data;
    assign PrbPu_win        = r_pu_win;
    assign PrbPu_ch         = r_pu_ch;
    assign pt_en            = r_pt_en;
    assign ptr              = r_ptr;
    assign ptc              = r_ptc;
    assign PrbPc_imgEnd     = r_img_end;
    assign PrbPc_imgEndAddr = r_img_end_addr;

endmodule

// File: tb/tb_pool_rd_bridge.sv
// Bench for pool_rd_bridge: memory model feeds a scoreboard, a monitor checks pool_unit outputs.
module tb_pool_rd_bridge;

    localparam int WL   = 32;
    localparam int CS   = 2;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int MO   = 4;
    localparam int NREQ = IW * IH * CS;

    logic          clk = 1'b0;
    logic          rst;
    logic          PcPrb_initAddrEn;
    logic [27:0]   PcPrb_initAddr;
    logic          PrbMem_rdReq;
    logic [27:0]   PrbMem_rdAddr;
    logic          MemPrb_rdGnt;
    logic          MemPrb_rdValid;
    logic [WL-1:0] MemPrb_rdData;
    logic          PrbPu_valid;
    logic [WL-1:0] PrbPu_data;
    logic [1:0]    PrbPu_win;
    logic [5:0]    PrbPu_ch;
    logic          pt_en;
    logic [5:0]    ptr;
    logic [5:0]    ptc;
    logic          PrbPc_imgEnd;
    logic [27:0]   PrbPc_imgEndAddr;

    always #5 clk = ~clk;

    pool_rd_bridge #(
        .word_len     (WL),
        .channel_size (CS),
        .img_w        (IW),
        .img_h        (IH),
        .max_outst    (MO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .PcPrb_initAddrEn (PcPrb_initAddrEn),
        .PcPrb_initAddr   (PcPrb_initAddr),
        .PrbMem_rdReq     (PrbMem_rdReq),
        .PrbMem_rdAddr    (PrbMem_rdAddr),
        .MemPrb_rdGnt     (MemPrb_rdGnt),
        .MemPrb_rdValid   (MemPrb_rdValid),
        .MemPrb_rdData    (MemPrb_rdData),
        .PrbPu_valid      (PrbPu_valid),
        .PrbPu_data       (PrbPu_data),
        .PrbPu_win        (PrbPu_win),
        .PrbPu_ch         (PrbPu_ch),
        .pt_en            (pt_en),
        .ptr              (ptr),
        .ptc              (ptc),
        .PrbPc_imgEnd     (PrbPc_imgEnd),
        .PrbPc_imgEndAddr (PrbPc_imgEndAddr)
    );

    typedef struct {
        logic [27:0] addr;
        logic [27:0] base;
        int          due;
        bit          live;
        int          ep;
        int          idx;
    } mem_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  win;
        logic [5:0]  ch;
        bit          pt;
        logic [5:0]  ptr;
        logic [5:0]  ptc;
        bit          iend;
        logic [27:0] iaddr;
    } exp_t;

    mem_t        mem_q[$];
    exp_t        exp_q[$];
    logic [27:0] grant_addr[$];

    int          n_err = 0;
    int          n_chk = 0;
    int          gnt_mode = 0;
    int          lat = 1;
    int          epoch = 0;
    logic [27:0] pass_base = '0;
    int          pass_idx = 0;
    int          n_grants = 0;
    int          n_pt = 0;
    int          n_iend = 0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference address of request idx of a pass starting at b
    function automatic logic [27:0] exp_addr(input logic [27:0] b, input int idx);
        int ch  = idx % CS;
        int dx  = (idx / CS) % 2;
        int dy  = (idx / (2 * CS)) % 2;
        int opc = (idx / (4 * CS)) % (IW / 2);
        int opr = idx / (4 * CS * (IW / 2));
        int row = 2 * opr + dy;
        int col = 2 * opc + dx;
        return b + 28'((row * IW + col) * CS + ch);
    endfunction

    // Memory model: grant pattern, in-order returns after 'lat' cycles, expectation push
    initial begin : mem_model
        logic        gnt;
        logic        ctl;
        logic        prev_req = 1'b0;
        logic        prev_gnt = 1'b0;
        logic        prev_ctl = 1'b1;
        logic [27:0] prev_addr = '0;
        mem_t        m;
        exp_t        x;
        int          ix;
        MemPrb_rdGnt   = 1'b0;
        MemPrb_rdValid = 1'b0;
        MemPrb_rdData  = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (prev_req && !prev_gnt && !prev_ctl) begin
                chk("req_hold", 64'(PrbMem_rdReq), 64'(1));
                chk("addr_hold", 64'(PrbMem_rdAddr), 64'(prev_addr));
            end
            gnt = (gnt_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            MemPrb_rdGnt = gnt;
            ctl = PcPrb_initAddrEn || rst;
            if (PrbMem_rdReq && gnt) begin
                n_grants++;
                m.addr = PrbMem_rdAddr;
                m.base = pass_base;
                m.due  = cyc + lat;
                m.live = !ctl;
                m.ep   = epoch;
                m.idx  = pass_idx;
                if (!ctl) begin
                    chk("grant_addr", 64'(PrbMem_rdAddr), 64'(exp_addr(pass_base, pass_idx)));
                    grant_addr.push_back(PrbMem_rdAddr);
                    pass_idx++;
                end
                mem_q.push_back(m);
                chk("outstanding_le_max", 64'(mem_q.size() <= MO), 64'(1));
            end
            if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                m = mem_q.pop_front();
                MemPrb_rdValid = 1'b1;
                MemPrb_rdData  = {4'hD, m.addr};
                if (m.live && m.ep == epoch && !ctl) begin
                    ix      = m.idx;
                    x.data  = {4'hD, m.addr};
                    x.win   = 2'(((ix / (2 * CS)) % 2) * 2 + (ix / CS) % 2);
                    x.ch    = 6'(ix % CS);
                    x.pt    = ((ix % (4 * CS)) == 4 * CS - 1);
                    x.ptc   = 6'((ix / (4 * CS)) % (IW / 2));
                    x.ptr   = 6'(ix / (4 * CS * (IW / 2)));
                    x.iend  = (ix == NREQ - 1);
                    x.iaddr = m.base + 28'(NREQ - 1);
                    exp_q.push_back(x);
                end
            end else begin
                MemPrb_rdValid = 1'b0;
                MemPrb_rdData  = '0;
            end
            prev_req  = PrbMem_rdReq;
            prev_gnt  = gnt;
            prev_addr = PrbMem_rdAddr;
            prev_ctl  = ctl;
        end
    end

    // Monitor: compares every pool_unit word against the scoreboard head
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (PrbPu_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_word: got data 0x%0h, required no output", PrbPu_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pu_data", 64'(PrbPu_data), 64'(e.data));
                    chk("pu_win", 64'(PrbPu_win), 64'(e.win));
                    chk("pu_ch", 64'(PrbPu_ch), 64'(e.ch));
                    chk("pt_en", 64'(pt_en), 64'(e.pt));
                    if (e.pt) begin
                        chk("ptr", 64'(ptr), 64'(e.ptr));
                        chk("ptc", 64'(ptc), 64'(e.ptc));
                    end
                    chk("img_end", 64'(PrbPc_imgEnd), 64'(e.iend));
                    if (e.iend) begin
                        chk("img_end_addr", 64'(PrbPc_imgEndAddr), 64'(e.iaddr));
                    end
                end
            end else if (pt_en || PrbPc_imgEnd) begin
                n_chk++;
                n_err++;
                $display("FAIL stray_pulse: got pt_en=%0d imgEnd=%0d, required 0 without valid",
                         pt_en, PrbPc_imgEnd);
            end
            if (pt_en) n_pt++;
            if (PrbPc_imgEnd) n_iend++;
        end
    end

    task automatic arm(input logic [27:0] b);
        @(negedge clk);
        PcPrb_initAddrEn = 1'b1;
        PcPrb_initAddr   = b;
        epoch++;
        pass_base = b;
        pass_idx  = 0;
        grant_addr.delete();
        @(negedge clk);
        PcPrb_initAddrEn = 1'b0;
    endtask

    task automatic wait_pass(input string name, input int iend0);
        int k = 0;
        while (n_iend == iend0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(n_iend - iend0), 64'(1));
    endtask

    task automatic wait_quiet();
        int k = 0;
        while ((mem_q.size() != 0 || exp_q.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("drained", 64'(mem_q.size() + exp_q.size()), 64'(0));
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (pass_idx < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("grant_progress", 64'(pass_idx >= n), 64'(1));
    endtask

    initial begin : stim
        int pt0;
        int ie0;
        int g0;
        rst              = 1'b1;
        PcPrb_initAddrEn = 1'b0;
        PcPrb_initAddr   = '0;
        epoch++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Reset state
        chk("rst_rdreq", 64'(PrbMem_rdReq), 64'(0));
        chk("rst_valid", 64'(PrbPu_valid), 64'(0));
        chk("rst_pt_en", 64'(pt_en), 64'(0));
        chk("rst_ptr_ptc", 64'({ptr, ptc}), 64'(0));
        chk("rst_img_end", 64'(PrbPc_imgEnd), 64'(0));
        chk("rst_img_end_addr", 64'(PrbPc_imgEndAddr), 64'(0));
        chk("rst_state_idle", 64'(dut.r_state), 64'(0));
        repeat (5) @(negedge clk);
        chk("no_start_unarmed", 64'(n_grants), 64'(0));

        // Pass A: always granted, one-cycle data latency
        gnt_mode = 0;
        lat      = 1;
        pt0 = n_pt;
        ie0 = n_iend;
        arm(28'h100);
        wait_pass("a_img_end", ie0);
        repeat (3) @(negedge clk);
        chk("a_first0", 64'(grant_addr[0]), 64'h100);
        chk("a_first1", 64'(grant_addr[1]), 64'h101);
        chk("a_first2", 64'(grant_addr[2]), 64'h102);
        chk("a_first3", 64'(grant_addr[3]), 64'h103);
        chk("a_first4", 64'(grant_addr[4]), 64'h108);
        chk("a_first5", 64'(grant_addr[5]), 64'h109);
        chk("a_requests", 64'(pass_idx), 64'(32));
        chk("a_pt_count", 64'(n_pt - pt0), 64'(4));
        chk("a_img_end_once", 64'(n_iend - ie0), 64'(1));
        chk("a_img_end_addr", 64'(PrbPc_imgEndAddr), 64'h11F);
        chk("a_state_done", 64'(dut.r_state), 64'(3));
        chk("a_req_low", 64'(PrbMem_rdReq), 64'(0));
        wait_quiet();

        // Pass B: grant toggling, long data latency
        gnt_mode = 1;
        lat      = 6;
        pt0 = n_pt;
        ie0 = n_iend;
        arm(28'h040);
        wait_pass("b_img_end", ie0);
        chk("b_requests", 64'(pass_idx), 64'(32));
        chk("b_pt_count", 64'(n_pt - pt0), 64'(4));
        wait_quiet();

        // Pass C: abort after 10 grants, restart at 0x200 with data still in flight
        gnt_mode = 0;
        lat      = 6;
        arm(28'h100);
        wait_grants(10);
        @(negedge clk);
        PcPrb_initAddrEn = 1'b1;
        PcPrb_initAddr   = 28'h200;
        epoch++;
        pass_base = 28'h200;
        pass_idx  = 0;
        grant_addr.delete();
        @(negedge clk);
        chk("c_abort_req_low", 64'(PrbMem_rdReq), 64'(0));
        chk("c_abort_state_idle", 64'(dut.r_state), 64'(0));
        pt0 = n_pt;
        ie0 = n_iend;
        @(negedge clk);
        PcPrb_initAddrEn = 1'b0;
        wait_pass("c_img_end", ie0);
        chk("c_restart_addr", 64'(grant_addr[0]), 64'h200);
        chk("c_requests", 64'(pass_idx), 64'(32));
        chk("c_pt_count", 64'(n_pt - pt0), 64'(4));
        wait_quiet();

        // Pass E: base near the top of the address space wraps
        gnt_mode = 0;
        lat      = 1;
        ie0 = n_iend;
        arm(28'hFFFFFFE);
        wait_pass("e_img_end", ie0);
        chk("e_addr1", 64'(grant_addr[1]), 64'hFFFFFFF);
        chk("e_wrap_addr", 64'(grant_addr[2]), 64'h0000000);
        chk("e_img_end_addr", 64'(PrbPc_imgEndAddr), 64'h000001D);
        wait_quiet();

        // Reset in the middle of a pass
        gnt_mode = 0;
        lat      = 2;
        arm(28'h100);
        wait_grants(5);
        @(negedge clk);
        rst = 1'b1;
        epoch++;
        @(negedge clk);
        rst = 1'b0;
        chk("d_rst_req_low", 64'(PrbMem_rdReq), 64'(0));
        chk("d_rst_valid_low", 64'(PrbPu_valid), 64'(0));
        chk("d_rst_state_idle", 64'(dut.r_state), 64'(0));
        g0 = n_grants;
        repeat (10) @(negedge clk);
        chk("d_no_restart", 64'(n_grants), 64'(g0));
        wait_quiet();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
